// File: rtl/cluster_header_pkg.sv
// Shared types and range limits for the cluster header.
// Counter widths are sized from the maximum parameter ranges.
package cluster_header_pkg;

    localparam int MAX_NUM_CL      = 16;
    localparam int MAX_SYNC_STAGES = 4;
    localparam int MAX_STAGGER     = 255;
    localparam int MAX_DBG_STRETCH = 255;

    localparam int IDX_W = $clog2(MAX_NUM_CL);
    localparam int CNT_W = $clog2(MAX_STAGGER + 1);
    localparam int STR_W = $clog2(MAX_DBG_STRETCH + 1);

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RELEASE  = 2'd1,
        RUN      = 2'd2
    } rel_state_t;

endpackage

// File: rtl/cluster_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit request.
// Clears to 0 under synchronous reset.
module cluster_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/cluster_header_mc.sv
// Cluster header: clock-enable staging, staggered per-cluster reset
// release, stretched debug init, and a short scan chain.
module cluster_header_mc
    import cluster_header_pkg::*;
#(
    parameter int NUM_CL      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGGER     = 4,
    parameter int DBG_STRETCH = 8
) (
    input  logic              gclk,
    input  logic              grst,
    input  logic              grst_l,
    input  logic              gdbginit_l,
    input  logic [NUM_CL-1:0] cluster_cken,
    input  logic              se,
    input  logic              si,
    output logic [NUM_CL-1:0] rclk_en,
    output logic [NUM_CL-1:0] cluster_grst_l,
    output logic [NUM_CL-1:0] dbginit_l,
    output logic              seq_busy,
    output logic              so
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CL - 1);
    localparam logic [CNT_W-1:0] STAG_END = CNT_W'(STAGGER - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(DBG_STRETCH);

    logic              grst_s;
    logic              dbg_s;
    logic              dbg_q;
    logic              dbg_fall;
    logic              dbg_ok;
    rel_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [STR_W-1:0]  stretch;
    logic [STR_W-1:0]  stretch_nxt;
    logic [NUM_CL-1:0] rel_bit;
    logic [NUM_CL-1:0] chain;

    cluster_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_grst_sync (
        .clk(gclk),
        .rst(grst),
        .d  (grst_l),
        .q  (grst_s)
    );

    cluster_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_dbg_sync (
        .clk(gclk),
        .rst(grst),
        .d  (gdbginit_l),
        .q  (dbg_s)
    );

    assign rel_bit = NUM_CL'(1) << idx;

    // Release sequencer; outputs are registered alongside the state.
    always_ff @(posedge gclk) begin
        if (grst) begin
            state          <= RST_HOLD;
            idx            <= '0;
            cnt            <= '0;
            cluster_grst_l <= '0;
            seq_busy       <= 1'b0;
        end else if (!grst_s) begin
            state          <= RST_HOLD;
            idx            <= '0;
            cnt            <= '0;
            cluster_grst_l <= '0;
            seq_busy       <= 1'b0;
        end else begin
            unique case (state)
                RST_HOLD: begin
                    cluster_grst_l <= '0;
                    seq_busy       <= 1'b0;
                    idx            <= '0;
                    cnt            <= '0;
                    state          <= RELEASE;
                end
                RELEASE: begin
                    seq_busy <= 1'b1;
                    if (cnt == '0) begin
                        cluster_grst_l <= cluster_grst_l | rel_bit;
                    end
                    if (cnt == '0 && idx == LAST_IDX) begin
                        state <= RUN;
                        idx   <= '0;
                        cnt   <= '0;
                    end else if (cnt == STAG_END) begin
                        idx <= idx + IDX_W'(1);
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    cluster_grst_l <= '1;
                    seq_busy       <= 1'b0;
                end
                default: begin
                    state          <= RST_HOLD;
                    cluster_grst_l <= '0;
                    seq_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_fall = dbg_q & ~dbg_s;

    always_comb begin
        stretch_nxt = stretch;
        if (dbg_fall) begin
            stretch_nxt = STR_LOAD;
        end else if (stretch != '0) begin
            stretch_nxt = stretch - STR_W'(1);
        end
    end

    // dbg_ok is low during a synchronized request or while stretching.
    always_ff @(posedge gclk) begin
        if (grst) begin
            dbg_q   <= 1'b0;
            stretch <= '0;
            dbg_ok  <= 1'b0;
        end else begin
            dbg_q   <= dbg_s;
            stretch <= stretch_nxt;
            dbg_ok  <= dbg_s & (stretch_nxt == '0);
        end
    end

    assign dbginit_l = cluster_grst_l & {NUM_CL{dbg_ok}};

    always_ff @(posedge gclk) begin
        if (grst) begin
            rclk_en <= '0;
            chain   <= '0;
        end else begin
            rclk_en <= se ? '1 : cluster_cken;
            if (se) begin
                chain <= NUM_CL'({chain, si});
            end
        end
    end

    assign so = chain[NUM_CL-1];

endmodule

// File: tb/tb_cluster_header_mc.sv
// Directed bench for cluster_header_mc at default parameters.
// Cycle n means the state just after the n-th edge after reset release.
module tb_cluster_header_mc;

    logic       gclk;
    logic       grst;
    logic       grst_l;
    logic       gdbginit_l;
    logic [3:0] cluster_cken;
    logic       se;
    logic       si;
    logic [3:0] rclk_en;
    logic [3:0] cluster_grst_l;
    logic [3:0] dbginit_l;
    logic       seq_busy;
    logic       so;

    int cyc;
    int n_chk;
    int n_err;

    cluster_header_mc #(
        .NUM_CL     (4),
        .SYNC_STAGES(2),
        .STAGGER    (4),
        .DBG_STRETCH(8)
    ) dut (
        .gclk          (gclk),
        .grst          (grst),
        .grst_l        (grst_l),
        .gdbginit_l    (gdbginit_l),
        .cluster_cken  (cluster_cken),
        .se            (se),
        .si            (si),
        .rclk_en       (rclk_en),
        .cluster_grst_l(cluster_grst_l),
        .dbginit_l     (dbginit_l),
        .seq_busy      (seq_busy),
        .so            (so)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge gclk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        cyc          = 0;
        grst         = 1'b1;
        grst_l       = 1'b0;
        gdbginit_l   = 1'b1;
        cluster_cken = 4'b0000;
        se           = 1'b0;
        si           = 1'b0;
        repeat (3) begin
            @(posedge gclk);
            #1;
        end
        check("rst_cgl", 32'(cluster_grst_l), 32'h0);
        check("rst_dbg", 32'(dbginit_l), 32'h0);
        check("rst_rclk", 32'(rclk_en), 32'h0);
        check("rst_busy", 32'(seq_busy), 32'h0);
        check("rst_so", 32'(so), 32'h0);
        grst = 1'b0;
        cyc  = 0;

        // staggered release, cken changes must not matter
        goto(9);
        grst_l       = 1'b1;
        cluster_cken = 4'b0110;
        goto(12);
        check("rel12_cgl", 32'(cluster_grst_l), 32'h0);
        check("rel12_busy", 32'(seq_busy), 32'h0);
        goto(13);
        check("rel13_cgl", 32'(cluster_grst_l), 32'h1);
        check("rel13_busy", 32'(seq_busy), 32'h1);
        check("cken_0110", 32'(rclk_en), 32'h6);
        cluster_cken = 4'b1010;
        goto(14);
        check("cken_1010", 32'(rclk_en), 32'ha);
        goto(16);
        check("rel16_cgl", 32'(cluster_grst_l), 32'h1);
        goto(17);
        check("rel17_cgl", 32'(cluster_grst_l), 32'h3);
        check("rel17_dbg", 32'(dbginit_l), 32'h3);
        goto(21);
        check("rel21_cgl", 32'(cluster_grst_l), 32'h7);
        goto(24);
        check("rel24_cgl", 32'(cluster_grst_l), 32'h7);
        goto(25);
        check("rel25_cgl", 32'(cluster_grst_l), 32'hf);
        check("rel25_busy", 32'(seq_busy), 32'h1);
        goto(26);
        check("run_busy", 32'(seq_busy), 32'h0);
        check("run_cgl", 32'(cluster_grst_l), 32'hf);
        se = 1'b1;
        goto(27);
        check("se_rclk", 32'(rclk_en), 32'hf);
        se = 1'b0;
        goto(28);
        check("se_off_rclk", 32'(rclk_en), 32'ha);

        // single debug pulse sampled at 31
        goto(30);
        gdbginit_l = 1'b0;
        goto(31);
        gdbginit_l = 1'b1;
        goto(32);
        check("dbg32", 32'(dbginit_l), 32'hf);
        goto(33);
        check("dbg33", 32'(dbginit_l), 32'h0);
        goto(40);
        check("dbg40", 32'(dbginit_l), 32'h0);
        goto(41);
        check("dbg41", 32'(dbginit_l), 32'hf);

        // pulses sampled at 50 and 53; reload extends the low
        goto(49);
        gdbginit_l = 1'b0;
        goto(50);
        gdbginit_l = 1'b1;
        goto(52);
        check("dbg52", 32'(dbginit_l), 32'h0);
        gdbginit_l = 1'b0;
        goto(53);
        gdbginit_l = 1'b1;
        goto(60);
        check("dbg60_ext", 32'(dbginit_l), 32'h0);
        goto(62);
        check("dbg62", 32'(dbginit_l), 32'h0);
        goto(63);
        check("dbg63", 32'(dbginit_l), 32'hf);

        // back to hold, then abort a fresh release midway
        goto(69);
        grst_l = 1'b0;
        goto(74);
        check("hold74_cgl", 32'(cluster_grst_l), 32'h0);
        goto(79);
        grst_l = 1'b1;
        goto(83);
        check("rel83_cgl", 32'(cluster_grst_l), 32'h1);
        goto(88);
        grst_l = 1'b0;
        goto(90);
        check("abort90_cgl", 32'(cluster_grst_l), 32'h3);
        check("abort90_busy", 32'(seq_busy), 32'h1);
        goto(92);
        check("abort92_cgl", 32'(cluster_grst_l), 32'h0);
        check("abort92_busy", 32'(seq_busy), 32'h0);
        goto(96);
        check("abort96_cgl", 32'(cluster_grst_l), 32'h0);

        // scan shift of 1,0,1,1 sampled at 100..103
        goto(99);
        se = 1'b1;
        si = 1'b1;
        goto(100);
        si = 1'b0;
        goto(101);
        si = 1'b1;
        goto(102);
        si = 1'b1;
        goto(103);
        check("so103", 32'(so), 32'h1);
        si = 1'b0;
        goto(104);
        check("so104", 32'(so), 32'h0);
        goto(105);
        check("so105", 32'(so), 32'h1);
        goto(106);
        check("so106", 32'(so), 32'h1);
        se = 1'b0;
        si = 1'b1;
        goto(109);
        check("so_hold", 32'(so), 32'h1);

        // reset hit mid-release with scan enabled
        grst_l = 1'b1;
        goto(117);
        check("rel117_cgl", 32'(cluster_grst_l), 32'h3);
        grst         = 1'b1;
        se           = 1'b1;
        cluster_cken = 4'b1111;
        goto(119);
        check("grst_cgl", 32'(cluster_grst_l), 32'h0);
        check("grst_dbg", 32'(dbginit_l), 32'h0);
        check("grst_busy", 32'(seq_busy), 32'h0);
        check("grst_rclk", 32'(rclk_en), 32'h0);
        check("grst_so", 32'(so), 32'h0);
        goto(121);
        grst = 1'b0;
        se   = 1'b0;
        goto(124);
        check("post124_cgl", 32'(cluster_grst_l), 32'h0);
        goto(125);
        check("post125_cgl", 32'(cluster_grst_l), 32'h1);
        check("post125_busy", 32'(seq_busy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
